// File: rtl/lane_tracker.sv
// lane_tracker: per-lane held/released tracking of PS/2 make/break events with
// autorepeat-suppressed hit/release pulses. Define LANE_TRACKER_HOLD_EN for hold-time counters.
module lane_tracker #(
  parameter int                     NUM_LANES  = 8,
  parameter logic [8*NUM_LANES-1:0] LANE_CODES = 64'h1c1b232b3b424b4c,
  parameter int                     HOLD_W     = 16
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             keyValid,
  input  logic [7:0]                       keyData,
  input  logic                             press,
  input  logic                             clear,
  output logic [NUM_LANES-1:0]             keyTrack,
  output logic [NUM_LANES-1:0]             hitPulse,
  output logic [NUM_LANES-1:0]             relPulse,
  output logic [$clog2(NUM_LANES+1)-1:0]   heldCount,
  output logic [NUM_LANES*HOLD_W-1:0]      holdTime
);

  localparam int CNT_W = $clog2(NUM_LANES+1);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} lane_state_e;

  lane_state_e          state_q [NUM_LANES];
  lane_state_e          state_d [NUM_LANES];
  logic [NUM_LANES-1:0] hit_q, hit_d;
  logic [NUM_LANES-1:0] rel_q, rel_d;
  logic [NUM_LANES-1:0] match;
  logic [CNT_W-1:0]     count_q, count_d;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      match[i] = keyValid && (keyData == LANE_CODES[8*i +: 8]);
    end
  end

  // Repeated makes while HELD fall through untouched, which is what suppresses autorepeat.
  always_comb begin
    hit_d   = '0;
    rel_d   = '0;
    count_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      if (clear) begin
        state_d[i] = IDLE;
      end else if (state_q[i] == IDLE) begin
        if (match[i] && press) begin
          state_d[i] = HELD;
          hit_d[i]   = 1'b1;
        end
      end else begin
        if (match[i] && !press) begin
          state_d[i] = IDLE;
          rel_d[i]   = 1'b1;
        end
      end
      if (state_d[i] == HELD) count_d = count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_LANES; i++) state_q[i] <= IDLE;
      hit_q   <= '0;
      rel_q   <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) state_q[i] <= state_d[i];
      hit_q   <= hit_d;
      rel_q   <= rel_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    keyTrack = '0;
    for (int i = 0; i < NUM_LANES; i++) keyTrack[i] = (state_q[i] == HELD);
  end

  assign hitPulse  = hit_q;
  assign relPulse  = rel_q;
  assign heldCount = count_q;

`ifdef LANE_TRACKER_HOLD_EN
  logic [HOLD_W-1:0] hold_q [NUM_LANES];
  logic [HOLD_W-1:0] hold_d [NUM_LANES];

  // Counter freezes on release so scoring can read it alongside relPulse.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      hold_d[i] = hold_q[i];
      if (clear || hit_d[i]) begin
        hold_d[i] = '0;
      end else if (state_q[i] == HELD && state_d[i] == HELD && hold_q[i] != '1) begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_LANES; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) hold_q[i] <= hold_d[i];
    end
  end

  always_comb begin
    holdTime = '0;
    for (int i = 0; i < NUM_LANES; i++) holdTime[HOLD_W*i +: HOLD_W] = hold_q[i];
  end
`else
  assign holdTime = '0;
`endif

endmodule

// File: tb/tb_lane_tracker.sv
// Scoreboard bench for lane_tracker: directed scenarios plus random events, checked against
// a lane-level reference model; a HOLD_W=4 instance exercises counter saturation.
module tb_lane_tracker;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         keyValid = 1'b0;
  logic [7:0]   keyData = '0;
  logic         press = 1'b0;
  logic         clear = 1'b0;
  logic [7:0]   keyTrack, hitPulse, relPulse;
  logic [3:0]   heldCount;
  logic [127:0] holdTime;
  logic [7:0]   keyTrack4, hitPulse4, relPulse4;
  logic [3:0]   heldCount4;
  logic [31:0]  holdTime4;

  always #5 Clk = ~Clk;

  lane_tracker dut (
    .Clk(Clk), .Reset(Reset), .keyValid(keyValid), .keyData(keyData), .press(press),
    .clear(clear), .keyTrack(keyTrack), .hitPulse(hitPulse), .relPulse(relPulse),
    .heldCount(heldCount), .holdTime(holdTime)
  );

  lane_tracker #(.HOLD_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .keyValid(keyValid), .keyData(keyData), .press(press),
    .clear(clear), .keyTrack(keyTrack4), .hitPulse(hitPulse4), .relPulse(relPulse4),
    .heldCount(heldCount4), .holdTime(holdTime4)
  );

  typedef struct {
    logic [7:0]   track;
    logic [7:0]   hit;
    logic [7:0]   rel;
    logic [3:0]   cnt;
    logic [127:0] h16;
    logic [31:0]  h4;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  logic [63:0] codes = 64'h1c1b232b3b424b4c;
  bit          m_held [8];
  int          m_h16  [8];
  int          m_h4   [8];

  function automatic logic [7:0] code(input int lane);
    return codes[8*lane +: 8];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  // Reference: each lane is a held flag plus an integer hold counter.
  task automatic model(input logic kv, input logic [7:0] kd, input logic pr, input logic clr);
    exp_t e;
    int   n = 0;
    e.hit = '0;
    e.rel = '0;
    for (int i = 0; i < 8; i++) begin
      bit m = kv && (kd == code(i));
      if (!Reset || clr) begin
        m_held[i] = 0; m_h16[i] = 0; m_h4[i] = 0;
      end else if (!m_held[i] && m && pr) begin
        m_held[i] = 1; e.hit[i] = 1'b1; m_h16[i] = 0; m_h4[i] = 0;
      end else if (m_held[i] && m && !pr) begin
        m_held[i] = 0; e.rel[i] = 1'b1;
      end else if (m_held[i]) begin
        m_h16[i] = (m_h16[i] + 1 > 65535) ? 65535 : m_h16[i] + 1;
        m_h4[i]  = (m_h4[i] + 1 > 15) ? 15 : m_h4[i] + 1;
      end
    end
    e.track = '0; e.h16 = '0; e.h4 = '0;
    for (int i = 0; i < 8; i++) begin
      e.track[i] = m_held[i];
      n += int'(m_held[i]);
`ifdef LANE_TRACKER_HOLD_EN
      e.h16[16*i +: 16] = 16'(m_h16[i]);
      e.h4[4*i +: 4]    = 4'(m_h4[i]);
`endif
    end
    e.cnt = 4'(n);
    q.push_back(e);
  endtask

  task automatic step(input logic rn, input logic kv, input logic [7:0] kd,
                      input logic pr, input logic clr);
    @(negedge Clk);
    Reset = rn; keyValid = kv; keyData = kd; press = pr; clear = clr;
    model(kv, kd, pr, clr);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic make(input logic [7:0] kd, input logic pr);
    step(1'b1, 1'b1, kd, pr, 1'b0);
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic async_reset();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("async_track", keyTrack, 0);
    chk("async_hit", hitPulse, 0);
    chk("async_rel", relPulse, 0);
    chk("async_cnt", heldCount, 0);
    chk("async_hold", holdTime, 0);
    chk("async_hold4", holdTime4, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("keyTrack", keyTrack, e.track);
        chk("hitPulse", hitPulse, e.hit);
        chk("relPulse", relPulse, e.rel);
        chk("heldCount", heldCount, e.cnt);
        chk("holdTime", holdTime, e.h16);
        chk("holdTime4", holdTime4, e.h4);
      end
    end
  end

  initial begin : driver
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(100);
    make(8'h1c, 1'b1);
    idle(10);
    for (int k = 0; k < 3; k++) begin
      make(8'h1c, 1'b1);
      idle(2);
    end
    make(8'h1c, 1'b0);
    idle(5);
    make(8'h4c, 1'b1);
    make(8'h4b, 1'b1);
    make(8'h42, 1'b1);
    step(1'b1, 1'b1, 8'h3b, 1'b1, 1'b1);
    idle(2);
    make(8'h29, 1'b1);
    make(8'h29, 1'b0);
    idle(2);
    make(8'h3b, 1'b0);
    make(8'h4c, 1'b1);
    idle(40);
    make(8'h4c, 1'b0);
    idle(3);
    make(8'h3b, 1'b1);
    idle(5);
    async_reset();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    make(8'h3b, 1'b0);
    idle(3);
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        logic [7:0] kd;
        kd = ($urandom_range(0, 3) != 0) ? code(int'($urandom_range(0, 7)))
                                         : 8'($urandom_range(0, 255));
        step(1'b1, 1'($urandom_range(0, 1)), kd, 1'($urandom_range(0, 1)),
             $urandom_range(0, 39) == 0);
      end
    end
    idle(1);
    repeat (3) @(posedge Clk);
    #2;
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
